// File: rtl/sccb_reg_init_seq.sv
// Camera register-init sequencer: walks a {reg_addr, reg_data} LUT and issues one SCCB write
// per entry, with power-up wait, in-table delays, early-end sentinel and NACK retry.
module sccb_reg_init_seq #(
  parameter int                    IDX_W       = 8,
  parameter int                    REG_ADDR_W  = 8,
  parameter int                    REG_DATA_W  = 8,
  parameter int                    LUT_BASE    = 2,
  parameter int                    LUT_COUNT   = 3,
  parameter int                    POWERUP_CYC = 1000000,
  parameter int                    GAP_CYC     = 1000,
  parameter logic [REG_ADDR_W-1:0] DELAY_TAG   = 8'hFF,
  parameter int                    DELAY_UNIT  = 50000,
  parameter int                    MAX_RETRY   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [IDX_W-1:0]               lut_index,
  input  logic [REG_ADDR_W+REG_DATA_W-1:0] lut_data,
  output logic                           i2c_valid,
  input  logic                           i2c_ready,
  output logic [REG_ADDR_W-1:0]          i2c_addr,
  output logic [REG_DATA_W-1:0]          i2c_wdata,
  input  logic                           i2c_done,
  input  logic                           i2c_nack,
  output logic                           init_done,
  output logic                           init_err,
  output logic [IDX_W-1:0]               entry_cnt,
  output logic [2:0]                     state_dbg
);

  localparam int DELAY_MAX = ((2 ** REG_DATA_W) - 1) * DELAY_UNIT;
  localparam int CNT_MAX_A = (POWERUP_CYC > GAP_CYC) ? POWERUP_CYC : GAP_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > DELAY_MAX) ? CNT_MAX_A : DELAY_MAX;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0]   FIRST_IDX  = IDX_W'(LUT_BASE + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(LUT_BASE + LUT_COUNT);
  localparam logic [CNT_W-1:0]   PWRUP_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DELAY = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     wait_cnt;
  logic [RETRY_W-1:0]   retry;
  logic [REG_ADDR_W-1:0] lut_addr;
  logic [REG_DATA_W-1:0] lut_wdata;
  logic                 last_entry;

  assign lut_addr   = lut_data[REG_ADDR_W+REG_DATA_W-1:REG_DATA_W];
  assign lut_wdata  = lut_data[REG_DATA_W-1:0];
  assign last_entry = (lut_index == LAST_IDX);
  assign state_dbg  = state;

  // Handshake: a request is transferred on the clock edge where i2c_valid && i2c_ready;
  // once valid is raised, valid/addr/wdata hold until that edge, then valid drops.
  // i2c_nack is meaningful only in the cycle i2c_done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PWRUP;
      lut_index <= FIRST_IDX;
      i2c_valid <= 1'b0;
      i2c_addr  <= '0;
      i2c_wdata <= '0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      entry_cnt <= '0;
      retry     <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_PWRUP: begin
          if (wait_cnt == PWRUP_LAST) begin
            wait_cnt <= '0;
            state    <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_FETCH: begin
          if (lut_data == '0) begin
            state     <= S_DONE;
            init_done <= 1'b1;
          end else if (lut_addr == DELAY_TAG) begin
            if (lut_wdata == '0) begin
              // zero-length delay still counts as a completed entry
              entry_cnt <= entry_cnt + IDX_W'(1);
              if (last_entry) begin
                state     <= S_DONE;
                init_done <= 1'b1;
              end else begin
                lut_index <= lut_index + IDX_W'(1);
                state     <= S_FETCH;
              end
            end else begin
              wait_cnt <= CNT_W'(lut_wdata) * CNT_W'(DELAY_UNIT);
              state    <= S_DELAY;
            end
          end else begin
            i2c_addr  <= lut_addr;
            i2c_wdata <= lut_wdata;
            i2c_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i2c_ready) begin
            i2c_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i2c_done) begin
            if (!i2c_nack) begin
              retry     <= '0;
              entry_cnt <= entry_cnt + IDX_W'(1);
              wait_cnt  <= '0;
              state     <= S_GAP;
            end else if (retry < RETRY_MAX) begin
              retry    <= retry + RETRY_W'(1);
              wait_cnt <= '0;
              state    <= S_GAP;
            end else begin
              init_err <= 1'b1;
              state    <= S_ERR;
            end
          end
        end
        S_DELAY: begin
          if (wait_cnt <= CNT_W'(1)) begin
            wait_cnt  <= '0;
            entry_cnt <= entry_cnt + IDX_W'(1);
            if (last_entry) begin
              state     <= S_DONE;
              init_done <= 1'b1;
            end else begin
              lut_index <= lut_index + IDX_W'(1);
              state     <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (wait_cnt == GAP_LAST) begin
            wait_cnt <= '0;
            // non-zero retry means the last attempt was NACKed: resend the held entry
            if (retry != '0) begin
              i2c_valid <= 1'b1;
              state     <= S_ISSUE;
            end else if (last_entry) begin
              state     <= S_DONE;
              init_done <= 1'b1;
            end else begin
              lut_index <= lut_index + IDX_W'(1);
              state     <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            init_done <= 1'b0;
            init_err  <= 1'b0;
            entry_cnt <= '0;
            retry     <= '0;
            lut_index <= FIRST_IDX;
            state     <= S_FETCH;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule
